// File: rtl/pcie_dllp_rx.sv
// DLLP receive path: link_up-gated input register, CRC-16 check and type decode, output FIFO, VC0 FC-init FSM.
// Latency 2 cycles from dllp_valid to out_valid (empty FIFO); out_ready backpressure, good DLLPs dropped and counted when the FIFO is full.
module pcie_dllp_rx #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  link_up,
    input  logic [DATA_WIDTH-1:0] dllp_in,
    input  logic                  dllp_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_kind,
    output logic [11:0]           out_seq,
    output logic [1:0]            out_fc_type,
    output logic [2:0]            out_vc,
    output logic [7:0]            out_hdr_fc,
    output logic [11:0]           out_data_fc,
    output logic                  fc_init_done,
    output logic [15:0]           crc_err_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] K_ACK     = 3'd0;
    localparam logic [2:0] K_NAK     = 3'd1;
    localparam logic [2:0] K_INITFC1 = 3'd2;
    localparam logic [2:0] K_INITFC2 = 3'd3;
    localparam logic [2:0] K_UPDFC   = 3'd4;
    localparam logic [2:0] K_PM      = 3'd5;
    localparam logic [2:0] K_VENDOR  = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [11:0] seq;
        logic [1:0]  fc_type;
        logic [2:0]  vc;
        logic [7:0]  hdr_fc;
        logic [11:0] data_fc;
    } ent_t;

    typedef enum logic [1:0] {
        FC_INIT1 = 2'd0,
        FC_INIT2 = 2'd1,
        FC_DONE  = 2'd2
    } fc_state_t;

    // Bits processed byte 0 first, LSB first; the inverted remainder is bit-reversed into bytes 6-7.
    function automatic logic [15:0] dllp_crc(input logic [47:0] m);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 48; i++) begin
            fb = c[15] ^ m[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        c = ~c;
        for (int k = 0; k < 16; k++) begin
            r[k] = c[15-k];
        end
        return r;
    endfunction

    logic            r_s1_vld;
    logic [63:0]     r_s1_dat;
    ent_t            r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_cnt;
    logic [15:0]     r_crc_err_cnt;
    logic [15:0]     r_drop_cnt;
    logic [2:0]      r_flags;
    fc_state_t       r_fc_state;
    fc_state_t       w_fc_nxt;

    logic            w_s2_vld;
    logic            w_crc_ok;
    logic            w_known;
    logic            w_good;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_crc_bad;
    logic            w_fc_vc0;
    logic [2:0]      w_flags_set;
    logic [7:0]      w_t;
    ent_t            w_ent;
    ent_t            w_head;

    generate
        if (DATA_WIDTH > 64) begin : g_upper
            logic w_unused;
            assign w_unused = ^dllp_in[DATA_WIDTH-1:64];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= dllp_valid & link_up;
            if (dllp_valid && link_up) begin
                r_s1_dat <= dllp_in[63:0];
            end
        end
    end

    assign w_s2_vld = r_s1_vld & link_up;
    assign w_crc_ok = (dllp_crc(r_s1_dat[47:0]) == r_s1_dat[63:48]);
    assign w_t      = r_s1_dat[7:0];

    always_comb begin
        w_ent   = '0;
        w_known = 1'b0;
        case (w_t)
            8'h00, 8'h10: begin
                w_known    = 1'b1;
                w_ent.kind = w_t[4] ? K_NAK : K_ACK;
                w_ent.seq  = {r_s1_dat[19:16], r_s1_dat[31:24]};
            end
            8'h20, 8'h21, 8'h23, 8'h24: begin
                w_known    = 1'b1;
                w_ent.kind = K_PM;
            end
            8'h30: begin
                w_known    = 1'b1;
                w_ent.kind = K_VENDOR;
            end
            default: begin
                if (w_t[7:6] != 2'b00 && w_t[5:4] != 2'b11 && !w_t[3]) begin
                    w_known       = 1'b1;
                    w_ent.kind    = (w_t[7:6] == 2'b01) ? K_INITFC1 :
                                    (w_t[7:6] == 2'b11) ? K_INITFC2 : K_UPDFC;
                    w_ent.fc_type = w_t[5:4];
                    w_ent.vc      = w_t[2:0];
                    w_ent.hdr_fc  = {r_s1_dat[13:8], r_s1_dat[23:22]};
                    w_ent.data_fc = {r_s1_dat[19:16], r_s1_dat[31:24]};
                end
            end
        endcase
    end

    assign w_good    = w_s2_vld & w_crc_ok & w_known;
    assign w_crc_bad = w_s2_vld & ~w_crc_ok;
    assign w_full    = (r_cnt == (PW+1)'(FIFO_DEPTH));
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_drop    = (w_s2_vld & w_crc_ok & ~w_known) | (w_good & w_full & ~w_pop);

    always_ff @(posedge clk) begin
        if (w_push && link_up) begin
            r_mem[r_wr_ptr] <= w_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (!link_up) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_err_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_crc_bad && r_crc_err_cnt != 16'hFFFF) begin
                r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // FC progress follows every good DLLP, including ones the full FIFO had to drop.
    assign w_fc_vc0    = w_good & (w_ent.vc == 3'd0);
    assign w_flags_set = (w_fc_vc0 && w_ent.kind == K_INITFC1) ? (3'b001 << w_ent.fc_type) : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_state <= FC_INIT1;
        end else begin
            r_fc_state <= w_fc_nxt;
        end
    end

    always_comb begin
        w_fc_nxt = r_fc_state;
        if (!link_up) begin
            w_fc_nxt = FC_INIT1;
        end else begin
            case (r_fc_state)
                FC_INIT1: if (&(r_flags | w_flags_set)) w_fc_nxt = FC_INIT2;
                FC_INIT2: if (w_fc_vc0 && (w_ent.kind == K_INITFC2 || w_ent.kind == K_UPDFC)) w_fc_nxt = FC_DONE;
                FC_DONE:  w_fc_nxt = FC_DONE;
                default:  w_fc_nxt = FC_INIT1;
            endcase
        end
    end

    always_comb begin
        fc_init_done = (r_fc_state == FC_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (!link_up || r_fc_state != FC_INIT1 || w_fc_nxt != FC_INIT1) begin
            r_flags <= '0;
        end else begin
            r_flags <= r_flags | w_flags_set;
        end
    end

    assign out_valid   = (r_cnt != '0);
    assign w_head      = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_kind    = w_head.kind;
    assign out_seq     = w_head.seq;
    assign out_fc_type = w_head.fc_type;
    assign out_vc      = w_head.vc;
    assign out_hdr_fc  = w_head.hdr_fc;
    assign out_data_fc = w_head.data_fc;
    assign crc_err_cnt = r_crc_err_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
